// File: rtl/litedram_bist_pkg.sv
// rtl/litedram_bist_pkg.sv - shared state encoding and pattern constants for the native-port BIST
package litedram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } bist_state_e;

  localparam logic [7:0]  PATTERN_TAG   = 8'hA5;
  localparam logic [7:0]  LFSR_SEED_TAG = 8'h5A;
  localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
  localparam int          LANE_W        = 32;

  function automatic int lane_count(input int data_w);
    return data_w / LANE_W;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/litedram_bist_pattern.sv
// rtl/litedram_bist_pattern.sv - combinational beat address to test pattern
// LITEDRAM_BIST_LFSR_EN selects the per-lane Galois LFSR pattern instead of {tag, addr}.
module litedram_bist_pattern
  import litedram_bist_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 256
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o
);

  localparam int LANES = lane_count(DATA_W);

  logic [23:0] addr24;

  if (ADDR_W >= 24) begin : g_trunc
    assign addr24 = addr_i[23:0];
  end else begin : g_ext
    assign addr24 = {{(24-ADDR_W){1'b0}}, addr_i};
  end

`ifdef LITEDRAM_BIST_LFSR_EN
  logic [31:0] lfsr;

  // Each lane takes the next LFSR state, so lanes within a beat differ.
  always_comb begin
    lfsr   = {LFSR_SEED_TAG, addr24};
    data_o = '0;
    for (int i = 0; i < LANES; i++) begin
      lfsr = lfsr_step(lfsr);
      data_o[i*LANE_W +: LANE_W] = lfsr;
    end
  end
`else
  always_comb begin
    data_o = '0;
    for (int i = 0; i < LANES; i++) begin
      data_o[i*LANE_W +: LANE_W] = {PATTERN_TAG, addr24};
    end
  end
`endif

endmodule

// File: rtl/litedram_native_bist.sv
// rtl/litedram_native_bist.sv - burst write/read-back pattern tester for one LiteDRAM native port
// Pattern source selectable with LITEDRAM_BIST_LFSR_EN (see litedram_bist_pattern).
module litedram_native_bist
  import litedram_bist_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 256,
  parameter int LEN_W  = 24,
  parameter int ERR_W  = 16
) (
  input  logic                  user_clk,
  input  logic                  user_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [LEN_W-1:0]      length,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [ERR_W-1:0]      err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic [2:0]            phase,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic                  cmd_we,
  output logic [ADDR_W-1:0]     cmd_addr,
  output logic                  wdata_valid,
  input  logic                  wdata_ready,
  output logic [DATA_W/8-1:0]   wdata_we,
  output logic [DATA_W-1:0]     wdata_data,
  input  logic                  rdata_valid,
  output logic                  rdata_ready,
  input  logic [DATA_W-1:0]     rdata_data
);

  bist_state_e       state_q;
  logic [ADDR_W-1:0] base_q, ferr_q;
  logic [LEN_W-1:0]  len_q, cmd_idx_q, wd_idx_q, rd_idx_q, outst_q;
  logic [LEN_W-1:0]  cmd_idx_d, wd_idx_d, rd_idx_d, outst_d;
  logic [ERR_W-1:0]  err_q;
  logic              busy_q, done_q, aborted_q;
  logic              cmd_valid_q, cmd_we_q, wdata_valid_q, rdata_ready_q;
  logic              cmd_fire, wd_fire, rd_fire, mismatch;
  logic [DATA_W-1:0] wr_pattern, rd_pattern;

  litedram_bist_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_pattern (
    .addr_i (base_q + ADDR_W'(wd_idx_q)),
    .data_o (wr_pattern)
  );

  litedram_bist_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd_pattern (
    .addr_i (base_q + ADDR_W'(rd_idx_q)),
    .data_o (rd_pattern)
  );

  always_comb begin
    cmd_fire  = cmd_valid_q & cmd_ready;
    wd_fire   = wdata_valid_q & wdata_ready;
    rd_fire   = rdata_ready_q & rdata_valid;
    cmd_idx_d = cmd_idx_q + LEN_W'(cmd_fire);
    wd_idx_d  = wd_idx_q + LEN_W'(wd_fire);
    rd_idx_d  = rd_idx_q + LEN_W'(rd_fire);
    // Only read commands create outstanding beats; simultaneous issue and return cancel out.
    outst_d   = outst_q + LEN_W'(cmd_fire & ~cmd_we_q) - LEN_W'(rd_fire);
    mismatch  = rd_fire && (state_q == ST_READ) && (rdata_data != rd_pattern);
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      len_q         <= '0;
      cmd_idx_q     <= '0;
      wd_idx_q      <= '0;
      rd_idx_q      <= '0;
      outst_q       <= '0;
      err_q         <= '0;
      ferr_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_we_q      <= 1'b0;
      wdata_valid_q <= 1'b0;
      rdata_ready_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            base_q    <= base_addr;
            len_q     <= length;
            cmd_idx_q <= '0;
            wd_idx_q  <= '0;
            rd_idx_q  <= '0;
            outst_q   <= '0;
            err_q     <= '0;
            ferr_q    <= '0;
            aborted_q <= 1'b0;
            if (length == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q       <= ST_WRITE;
              busy_q        <= 1'b1;
              cmd_valid_q   <= 1'b1;
              cmd_we_q      <= 1'b1;
              wdata_valid_q <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          cmd_idx_q     <= cmd_idx_d;
          wd_idx_q      <= wd_idx_d;
          cmd_valid_q   <= (cmd_idx_d < len_q);
          wdata_valid_q <= (wd_idx_d < len_q);
          if (abort) begin
            state_q       <= ST_DONE;
            done_q        <= 1'b1;
            busy_q        <= 1'b0;
            aborted_q     <= 1'b1;
            cmd_valid_q   <= 1'b0;
            wdata_valid_q <= 1'b0;
          end else if ((cmd_idx_d == len_q) && (wd_idx_d == len_q)) begin
            state_q       <= ST_READ;
            cmd_idx_q     <= '0;
            wd_idx_q      <= '0;
            cmd_valid_q   <= 1'b1;
            cmd_we_q      <= 1'b0;
            wdata_valid_q <= 1'b0;
            rdata_ready_q <= 1'b1;
          end
        end
        ST_READ: begin
          cmd_idx_q   <= cmd_idx_d;
          rd_idx_q    <= rd_idx_d;
          outst_q     <= outst_d;
          cmd_valid_q <= (cmd_idx_d < len_q);
          if (mismatch) begin
            if (err_q != '1)
              err_q <= err_q + ERR_W'(1);
            if (err_q == '0)
              ferr_q <= base_q + ADDR_W'(rd_idx_q);
          end
          if (abort) begin
            cmd_valid_q <= 1'b0;
            if (outst_d != '0) begin
              state_q <= ST_DRAIN;
            end else begin
              state_q       <= ST_DONE;
              done_q        <= 1'b1;
              busy_q        <= 1'b0;
              aborted_q     <= 1'b1;
              rdata_ready_q <= 1'b0;
            end
          end else if (rd_idx_d == len_q) begin
            state_q       <= ST_DONE;
            done_q        <= 1'b1;
            busy_q        <= 1'b0;
            cmd_valid_q   <= 1'b0;
            rdata_ready_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          outst_q <= outst_d;
          if (outst_d == '0) begin
            state_q       <= ST_DONE;
            done_q        <= 1'b1;
            busy_q        <= 1'b0;
            aborted_q     <= 1'b1;
            rdata_ready_q <= 1'b0;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign aborted        = aborted_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;
  assign phase          = state_q;
  assign cmd_valid      = cmd_valid_q;
  assign cmd_we         = cmd_we_q;
  assign cmd_addr       = base_q + ADDR_W'(cmd_idx_q);
  assign wdata_valid    = wdata_valid_q;
  assign wdata_we       = '1;
  assign wdata_data     = wr_pattern;
  assign rdata_ready    = rdata_ready_q;

endmodule

// File: tb/tb_litedram_native_bist.sv
// tb/tb_litedram_native_bist.sv - directed bench for litedram_native_bist with an in-order native-port model
module tb_litedram_native_bist;

  logic         user_clk, user_rst, start, abort;
  logic [23:0]  base_addr, length;
  logic         busy, done, aborted;
  logic [15:0]  err_count;
  logic [23:0]  first_err_addr;
  logic [2:0]   phase;
  logic         cmd_valid, cmd_ready, cmd_we;
  logic [23:0]  cmd_addr;
  logic         wdata_valid, wdata_ready;
  logic [31:0]  wdata_we;
  logic [255:0] wdata_data;
  logic         rdata_valid, rdata_ready;
  logic [255:0] rdata_data;

  litedram_native_bist dut (
    .user_clk(user_clk), .user_rst(user_rst), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length), .busy(busy), .done(done),
    .aborted(aborted), .err_count(err_count), .first_err_addr(first_err_addr),
    .phase(phase), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .wdata_we(wdata_we), .wdata_data(wdata_data), .rdata_valid(rdata_valid),
    .rdata_ready(rdata_ready), .rdata_data(rdata_data)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  int n_chk = 0, n_bad = 0;
  int cyc = 0, done_cnt, cv_cycles, stab_bad, wd_cnt, wd_bad, rd_cmds, rd_ret, waited;
  int flip_beat, rd_lat;
  bit stall_en, saw_drain, abort_sent;
  logic [23:0]  run_base;
  logic [23:0]  wa_q[$], ra_q[$];
  logic [255:0] rq_data[$];
  int           rq_due[$];
  logic         prev_cv, prev_cr, prev_cw, prev_wv, prev_wr;
  logic [23:0]  prev_ca;
  logic [255:0] prev_wd;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] pat(input logic [23:0] a);
    logic [255:0] p;
    for (int i = 0; i < 8; i++) p[i*32 +: 32] = {8'hA5, a};
    return p;
  endfunction

  task automatic reset_logs();
    done_cnt = 0; cv_cycles = 0; stab_bad = 0; wd_cnt = 0; wd_bad = 0;
    rd_cmds = 0; rd_ret = 0; saw_drain = 0; abort_sent = 0;
    wa_q.delete(); ra_q.delete(); rq_data.delete(); rq_due.delete();
    prev_cv = 0; prev_cr = 0; prev_cw = 0; prev_wv = 0; prev_wr = 0;
    prev_ca = '0; prev_wd = '0;
  endtask

  // One cycle: observe DUT outputs at the negedge and drive the core model for the next posedge.
  task automatic tick();
    @(negedge user_clk);
    cyc++;
    if (done) done_cnt++;
    if (cmd_valid) cv_cycles++;
    if (phase == 3'd3) saw_drain = 1;
    if (prev_cv && !prev_cr && (!cmd_valid || cmd_addr !== prev_ca || cmd_we !== prev_cw)) stab_bad++;
    if (prev_wv && !prev_wr && (!wdata_valid || wdata_data !== prev_wd)) stab_bad++;
    cmd_ready   = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    wdata_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    if (cmd_valid && cmd_ready) begin
      if (cmd_we) wa_q.push_back(cmd_addr);
      else begin
        ra_q.push_back(cmd_addr);
        rq_due.push_back(cyc + rd_lat);
        rq_data.push_back(pat(cmd_addr) ^ ((rd_cmds == flip_beat) ? 256'd1 : 256'd0));
        rd_cmds++;
      end
    end
    if (wdata_valid && wdata_ready) begin
      if (wdata_data !== pat(run_base + 24'(wd_cnt)) || wdata_we !== 32'hFFFF_FFFF) wd_bad++;
      wd_cnt++;
    end
    if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
      rdata_valid = 1'b1;
      rdata_data  = rq_data[0];
      if (rdata_ready) begin
        void'(rq_due.pop_front());
        void'(rq_data.pop_front());
        rd_ret++;
      end
    end else begin
      rdata_valid = 1'b0;
    end
    prev_cv = cmd_valid; prev_cr = cmd_ready; prev_cw = cmd_we; prev_ca = cmd_addr;
    prev_wv = wdata_valid; prev_wr = wdata_ready; prev_wd = wdata_data;
  endtask

  task automatic run(input logic [23:0] b, input logic [23:0] n, input int flip, input bit stl,
                     input int lat, input int abort_at, input bit busy_start);
    reset_logs();
    flip_beat = flip; stall_en = stl; rd_lat = lat; run_base = b;
    base_addr = b; length = n; start = 1'b1;
    tick();
    start = 1'b0;
    if (n != 0) check("first_cmd_valid", cmd_valid, 1'b1);
    waited = 0;
    while (!done && waited < 400) begin
      start = busy_start && (waited == 2);
      if (start) begin base_addr = 24'h000999; length = 24'd7; end
      abort = (abort_at >= 0) && !abort_sent && (rd_cmds == abort_at);
      if (abort) abort_sent = 1;
      tick();
      waited++;
    end
    start = 1'b0; abort = 1'b0;
    check("done_seen", done, 1'b1);
    repeat (3) tick();
  endtask

  task automatic check_addrs(input string tag, input logic [23:0] b);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_wa%0d", tag, i), (i < wa_q.size()) ? wa_q[i] : 24'hBAD0BA, 24'(b + 24'(i)));
  endtask

  initial begin
    user_rst = 1'b1; start = 0; abort = 0; base_addr = '0; length = '0;
    cmd_ready = 1; wdata_ready = 1; rdata_valid = 0; rdata_data = '0;
    flip_beat = -1; stall_en = 0; rd_lat = 3; run_base = '0;
    reset_logs();
    repeat (3) tick();
    user_rst = 1'b0;
    tick();
    check("rst_busy", busy, 0);         check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);   check("rst_err", err_count, 0);
    check("rst_ferr", first_err_addr, 0); check("rst_phase", phase, 0);
    check("rst_cmd_valid", cmd_valid, 0); check("rst_wdata_valid", wdata_valid, 0);
    check("rst_rdata_ready", rdata_ready, 0);

    run(24'h000100, 24'd4, -1, 0, 3, -1, 0);
    check_addrs("basic", 24'h000100);
    check("basic_reads", ra_q.size(), 4);   check("basic_wdata", wd_cnt, 4);
    check("basic_wdata_bad", wd_bad, 0);    check("basic_err", err_count, 0);
    check("basic_aborted", aborted, 0);     check("basic_done_pulses", done_cnt, 1);
    check("basic_busy_after", busy, 0);

    run(24'h000100, 24'd4, 2, 0, 3, -1, 0);
    check("flip_err", err_count, 1);        check("flip_ferr", first_err_addr, 24'h000102);
    check("flip_aborted", aborted, 0);

    run(24'hFFFFFE, 24'd4, -1, 0, 3, -1, 0);
    check_addrs("wrap", 24'hFFFFFE);
    check("wrap_wdata_bad", wd_bad, 0);     check("wrap_err", err_count, 0);

    run(24'h000700, 24'd4, -1, 1, 3, -1, 0);
    check("stall_stable", stab_bad, 0);     check("stall_wcmds", wa_q.size(), 4);
    check("stall_wdata", wd_cnt, 4);        check("stall_wdata_bad", wd_bad, 0);
    check("stall_reads", ra_q.size(), 4);   check("stall_err", err_count, 0);

    run(24'h000300, 24'd4, 0, 0, 8, 2, 0);
    check("drain_seen", saw_drain, 1);      check("drain_aborted", aborted, 1);
    check("drain_err", err_count, 0);       check("drain_rcmds", ra_q.size(), 2);
    check("drain_returned", rd_ret, 2);     check("drain_done_pulses", done_cnt, 1);

    run(24'h000200, 24'd4, -1, 0, 3, -1, 1);
    check_addrs("busy_start", 24'h000200);
    check("busy_start_wcmds", wa_q.size(), 4);
    check("busy_start_done_pulses", done_cnt, 1);
    check("busy_start_aborted", aborted, 0);

    run(24'h000500, 24'd0, -1, 0, 3, -1, 0);
    check("len0_latency", waited, 0);       check("len0_cmd_cycles", cv_cycles, 0);
    check("len0_done_pulses", done_cnt, 1); check("len0_wdata", wd_cnt, 0);

    reset_logs();
    base_addr = 24'h000400; length = 24'd8; start = 1'b1;
    tick();
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    check("wabort_phase", phase, 3'd4);     check("wabort_done", done, 1);
    check("wabort_aborted", aborted, 1);    check("wabort_cmd_valid", cmd_valid, 0);
    check("wabort_wdata_valid", wdata_valid, 0);
    tick();
    check("wabort_idle", phase, 3'd0);

    reset_logs();
    base_addr = 24'h000600; length = 24'd8; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("midrst_busy_before", busy, 1);
    user_rst = 1'b1;
    tick();
    user_rst = 1'b0;
    check("midrst_busy", busy, 0);          check("midrst_cmd_valid", cmd_valid, 0);
    check("midrst_wdata_valid", wdata_valid, 0); check("midrst_phase", phase, 0);
    check("midrst_done", done, 0);          check("midrst_rdata_ready", rdata_ready, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
